// File: rtl/decision_tx_framer.sv
// Serialises each accepted decision (type, data, ingress/decision timestamps) into an
// 11-byte frame: sync, type, data[4], latency[4], XOR checksum over bytes 1..9.
module decision_tx_framer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_type,
    input  logic [31:0]      in_data,
    input  logic [31:0]      in_t_ingress,
    input  logic [31:0]      in_t_decision,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent,
    output logic [31:0]      last_latency
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [7:0]  typ;
    logic [7:0]  chk;
    logic [31:0] data;
    logic [31:0] lat;
    logic [31:0] lat_in;

    // Unsigned modulo-2^32 difference, so a wrapped timestamp still yields the true latency
    assign lat_in   = in_t_decision - in_t_ingress;
    assign in_ready = (state == IDLE);
    assign busy     = (state == SEND);

    function automatic logic [7:0] xor_bytes(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    function automatic logic [7:0] frame_byte(
        input logic [3:0]  i,
        input logic [7:0]  t,
        input logic [31:0] d,
        input logic [31:0] l,
        input logic [7:0]  c
    );
        case (i)
            4'd0:    return SYNC_BYTE;
            4'd1:    return t;
            4'd2:    return d[31:24];
            4'd3:    return d[23:16];
            4'd4:    return d[15:8];
            4'd5:    return d[7:0];
            4'd6:    return l[31:24];
            4'd7:    return l[23:16];
            4'd8:    return l[15:8];
            4'd9:    return l[7:0];
            4'd10:   return c;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= 4'd0;
            typ          <= 8'h00;
            data         <= 32'h0;
            lat          <= 32'h0;
            chk          <= 8'h00;
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
            frames_sent  <= '0;
            last_latency <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        typ          <= in_type;
                        data         <= in_data;
                        lat          <= lat_in;
                        // Checksum is fixed at capture so byte 10 needs no running accumulator
                        chk          <= in_type ^ xor_bytes(in_data) ^ xor_bytes(lat_in);
                        last_latency <= lat_in;
                        tx_data      <= SYNC_BYTE;
                        tx_valid     <= 1'b1;
                        idx          <= 4'd0;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (idx == 4'd10) begin
                            state       <= IDLE;
                            tx_valid    <= 1'b0;
                            tx_data     <= 8'h00;
                            idx         <= 4'd0;
                            frames_sent <= frames_sent + CNT_W'(1);
                        end else begin
                            idx     <= idx + 4'd1;
                            tx_data <= frame_byte(idx + 4'd1, typ, data, lat, chk);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decision_tx_framer.sv
// Directed bench for decision_tx_framer: single frame, timestamp wrap, backpressure,
// back-to-back decisions, mid-frame reset and frame counter wrap (CNT_W=4).
module tb_decision_tx_framer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_type;
    logic [31:0] in_data;
    logic [31:0] in_t_ingress;
    logic [31:0] in_t_decision;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [3:0]  frames_sent;
    logic [31:0] last_latency;

    int total = 0;
    int bad   = 0;
    logic [7:0] eb [11];
    logic [7:0] b2b_exp [33];

    decision_tx_framer #(.SYNC_BYTE(8'hA5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_data(in_data),
        .in_t_ingress(in_t_ingress), .in_t_decision(in_t_decision),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frames_sent(frames_sent), .last_latency(last_latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame from fields; checksum is XOR of bytes 1..9
    task automatic build(input logic [7:0] t, input logic [31:0] d, input logic [31:0] l);
        eb[0] = 8'hA5; eb[1] = t;
        eb[2] = d[31:24]; eb[3] = d[23:16]; eb[4] = d[15:8]; eb[5] = d[7:0];
        eb[6] = l[31:24]; eb[7] = l[23:16]; eb[8] = l[15:8]; eb[9] = l[7:0];
        eb[10] = 8'h00;
        for (int i = 1; i < 10; i++) eb[10] = eb[10] ^ eb[i];
    endtask

    // Called at a negedge; drives the decision and returns at the negedge after acceptance
    task automatic accept(input logic [7:0] t, input logic [31:0] d,
                          input logic [31:0] ti, input logic [31:0] td);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ck("accept_ready", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1; in_type = t; in_data = d; in_t_ingress = ti; in_t_decision = td;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // mode 0: tx_ready held high; mode 1: 5-cycle stall at idx 3 then random
    task automatic rx_frame(input int mode, input string tag, output int ncyc);
        int   idx = 0;
        int   stall = 0;
        logic held_v = 1'b0;
        logic [7:0] held = 8'h00;
        logic inr_seen = 1'b0;
        ncyc = 0;
        while (idx < 11 && ncyc < 300) begin
            if (mode == 0 || idx < 3) tx_ready = 1'b1;
            else if (stall < 5) begin tx_ready = 1'b0; stall++; end
            else tx_ready = 1'($urandom_range(0, 1));
            if (held_v) begin
                ck($sformatf("%s_hold", tag), {24'h0, tx_data}, {24'h0, held});
                held_v = 1'b0;
            end
            if (in_ready) inr_seen = 1'b1;
            if (tx_valid && !tx_ready) begin held = tx_data; held_v = 1'b1; end
            if (tx_valid && tx_ready) begin
                if (idx == 0) ck($sformatf("%s_busy", tag), {31'h0, busy}, 32'h1);
                ck($sformatf("%s_b%0d", tag, idx), {24'h0, tx_data}, {24'h0, eb[idx]});
                idx++;
            end
            ncyc++;
            @(negedge clk);
        end
        tx_ready = 1'b1;
        ck($sformatf("%s_done", tag), idx, 11);
        ck($sformatf("%s_inready_low", tag), {31'h0, inr_seen}, 32'h0);
        ck($sformatf("%s_idle", tag), {30'h0, in_ready, busy}, 32'h2);
    endtask

    initial begin
        int n;
        int head;
        int cyc;
        int got;
        int inr_cnt;
        int acc_cyc [3];
        logic [7:0]  qt [3];
        logic [31:0] qd [3];
        logic [31:0] qi [3];
        logic [31:0] qe [3];

        rst = 1'b1; in_valid = 1'b0; in_type = 8'h0; in_data = 32'h0;
        in_t_ingress = 32'h0; in_t_decision = 32'h0; tx_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        ck("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        ck("rst_tx_data", {24'h0, tx_data}, 32'h0);
        ck("rst_busy", {31'h0, busy}, 32'h0);
        ck("rst_frames", {28'h0, frames_sent}, 32'h0);
        ck("rst_latency", last_latency, 32'h0);
        ck("rst_in_ready", {31'h0, in_ready}, 32'h1);
        rst = 1'b0;
        @(negedge clk);

        // Single frame, hand-computed bytes
        eb = '{8'hA5, 8'h42, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h1E, 8'h7A};
        accept(8'h42, 32'h0000_1234, 32'd100, 32'd130);
        rx_frame(0, "single", n);
        ck("single_cycles", n, 11);
        ck("single_frames", {28'h0, frames_sent}, 32'd1);
        ck("single_latency", last_latency, 32'h1E);

        // Timestamp wrap: latency 0x20, checksum 81^DE^AD^BE^EF^20 = 83
        eb = '{8'hA5, 8'h81, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h20, 8'h83};
        accept(8'h81, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 32'h0000_0010);
        rx_frame(0, "wrap", n);
        ck("wrap_latency", last_latency, 32'h20);
        ck("wrap_frames", {28'h0, frames_sent}, 32'd2);

        // Backpressure
        build(8'h5A, 32'h89AB_CDEF, 32'h106);
        accept(8'h5A, 32'h89AB_CDEF, 32'd10, 32'h110);
        rx_frame(1, "bp", n);
        ck("bp_frames", {28'h0, frames_sent}, 32'd3);

        // Back-to-back: in_valid held high with three queued decisions
        qt = '{8'h01, 8'h02, 8'hFF};
        qd = '{32'h1122_3344, 32'hCAFE_BABE, 32'h0};
        qi = '{32'd0, 32'd1000, 32'd7};
        qe = '{32'd5, 32'd1000, 32'd3};
        for (int k = 0; k < 3; k++) begin
            build(qt[k], qd[k], qe[k] - qi[k]);
            for (int i = 0; i < 11; i++) b2b_exp[k*11 + i] = eb[i];
        end
        head = 0; cyc = 0; got = 0; inr_cnt = 0;
        acc_cyc = '{-100, -100, -100};
        tx_ready = 1'b1;
        while (got < 33 && cyc < 100) begin
            if (head < 3) begin
                in_valid = 1'b1; in_type = qt[head]; in_data = qd[head];
                in_t_ingress = qi[head]; in_t_decision = qe[head];
            end else in_valid = 1'b0;
            if (tx_valid) begin
                ck($sformatf("b2b_b%0d", got), {24'h0, tx_data}, {24'h0, b2b_exp[got]});
                got++;
            end
            if (in_ready && head < 3) begin
                inr_cnt++;
                acc_cyc[head] = cyc;
                head++;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        ck("b2b_bytes", got, 33);
        ck("b2b_period1", acc_cyc[1] - acc_cyc[0], 12);
        ck("b2b_period2", acc_cyc[2] - acc_cyc[1], 12);
        ck("b2b_ready_pulses", inr_cnt, 3);
        @(negedge clk);
        ck("b2b_frames", {28'h0, frames_sent}, 32'd6);

        // Mid-frame reset at idx 6
        build(8'h33, 32'h0102_0304, 32'd9);
        accept(8'h33, 32'h0102_0304, 32'd0, 32'd9);
        for (int i = 0; i < 6; i++) @(negedge clk);
        ck("mrst_at_b6", {24'h0, tx_data}, {24'h0, eb[6]});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ck("mrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        ck("mrst_busy", {31'h0, busy}, 32'h0);
        ck("mrst_frames", {28'h0, frames_sent}, 32'd0);
        ck("mrst_latency", last_latency, 32'h0);
        @(negedge clk); @(negedge clk);
        ck("mrst_quiet", {31'h0, tx_valid}, 32'h0);
        build(8'h44, 32'h5566_7788, 32'd1);
        accept(8'h44, 32'h5566_7788, 32'd3, 32'd4);
        rx_frame(0, "fresh", n);
        ck("fresh_frames", {28'h0, frames_sent}, 32'd1);

        // Counter wrap: 15 more frames reach 16 -> 0, the 17th reads 1
        for (int i = 1; i <= 16; i++) begin
            build(8'(i), 32'(i) * 32'h0101_0101, 32'(i));
            accept(8'(i), 32'(i) * 32'h0101_0101, 32'(i), 32'(2 * i));
            rx_frame(0, $sformatf("cw%0d", i), n);
            if (i == 15) ck("cnt_wrap_zero", {28'h0, frames_sent}, 32'd0);
        end
        ck("cnt_wrap_one", {28'h0, frames_sent}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
